// File: rtl/seg7_scan_capture.sv
// Receiver for a multiplexed 4-digit seven-segment scan: settles each digit
// window, decodes it back to a hex nibble and publishes complete frames.
module seg7_scan_capture #(
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int EN_ACTIVE_LOW  = 0,
  parameter int SETTLE         = 4,
  parameter int TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  en_in,
  output logic [15:0] digit_code,
  output logic [3:0]  digit_dp,
  output logic [3:0]  digit_blank,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int              SW        = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      SETTLE_C  = 4'(SETTLE);
  localparam logic [SW-1:0]   TIMEOUT_C = SW'(TIMEOUT);

  // Returns {err, blank, nibble}.
  function automatic logic [5:0] decode7(input logic [6:0] s);
    case (s)
      7'h3F:   return 6'h00;
      7'h06:   return 6'h01;
      7'h5B:   return 6'h02;
      7'h4F:   return 6'h03;
      7'h66:   return 6'h04;
      7'h6D:   return 6'h05;
      7'h7D:   return 6'h06;
      7'h07:   return 6'h07;
      7'h7F:   return 6'h08;
      7'h6F:   return 6'h09;
      7'h77:   return 6'h0A;
      7'h7C:   return 6'h0B;
      7'h39:   return 6'h0C;
      7'h5E:   return 6'h0D;
      7'h79:   return 6'h0E;
      7'h71:   return 6'h0F;
      7'h00:   return 6'b01_0000;
      default: return 6'b10_0000;
    endcase
  endfunction

  logic [7:0]    seg_n, seg_q;
  logic [3:0]    en_n, en_q;
  logic [11:0]   prev_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          changed, onehot, capture, commit;
  logic [5:0]    dec;
  logic [15:0]   code_sh_q, code_sh_d;
  logic [3:0]    dp_sh_q, dp_sh_d, blank_sh_q, blank_sh_d, err_sh_q, err_sh_d;
  logic [3:0]    seen_q, seen_d, seen_all;
  logic [15:0]   code_q;
  logic [3:0]    dp_q, blank_q, err_q;
  logic          frame_valid_q, stale_q, stale_d;
  logic [SW-1:0] stale_cnt_q, stale_cnt_d;

  assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
  assign en_n  = (EN_ACTIVE_LOW  != 0) ? ~en_in  : en_in;

  // cnt_d is the settle count for the registered value in the current cycle.
  assign changed = ({en_q, seg_q} != prev_q);
  assign cnt_d   = changed ? 4'd1 : ((cnt_q == SETTLE_C) ? cnt_q : cnt_q + 4'd1);
  assign onehot  = (en_q != 4'd0) && ((en_q & (en_q - 4'd1)) == 4'd0);
  assign capture = onehot && (cnt_d == SETTLE_C) && (changed || cnt_q != SETTLE_C);
  assign dec     = decode7(seg_q[6:0]);

  assign seen_all = seen_q | en_q;
  assign commit   = capture && (seen_all == 4'hF);
  assign seen_d   = commit ? 4'd0 : (capture ? seen_all : seen_q);

  always_comb begin
    code_sh_d  = code_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    err_sh_d   = err_sh_q;
    if (capture) begin
      for (int k = 0; k < 4; k++) begin
        if (en_q[k]) begin
          code_sh_d[4*k +: 4] = dec[3:0];
          dp_sh_d[k]          = seg_q[7];
          blank_sh_d[k]       = dec[4];
          err_sh_d[k]         = dec[5];
        end
      end
    end
  end

  // A commit restarts the timeout even in the cycle it would have expired.
  assign stale_cnt_d = commit ? '0 :
                       ((stale_cnt_q == TIMEOUT_C) ? stale_cnt_q : stale_cnt_q + 1'b1);
  assign stale_d     = (stale_cnt_d == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= '0;
      en_q          <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      code_sh_q     <= '0;
      dp_sh_q       <= '0;
      blank_sh_q    <= '0;
      err_sh_q      <= '0;
      seen_q        <= '0;
      code_q        <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b0;
    end else begin
      seg_q         <= seg_n;
      en_q          <= en_n;
      prev_q        <= {en_q, seg_q};
      cnt_q         <= cnt_d;
      code_sh_q     <= code_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      err_sh_q      <= err_sh_d;
      seen_q        <= seen_d;
      frame_valid_q <= commit;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
      if (commit) begin
        code_q  <= code_sh_d;
        dp_q    <= dp_sh_d;
        blank_q <= blank_sh_d;
        err_q   <= err_sh_d;
      end
    end
  end

  assign digit_code  = code_q;
  assign digit_dp    = dp_q;
  assign digit_blank = blank_q;
  assign digit_err   = err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiver for the multiplexed 4-digit seven-segment bus (8 segment lines plus 4 digit enables) that the calculator display driver produces.
- Watches the scan, waits for each digit window to settle, and decodes each segment pattern back to a hex nibble.
- Once all four digits have been captured, publishes them as one coherent frame.
- Used for on-chip self-check, and as a bench monitor for the display path.

Parameters:
- SEG_ACTIVE_LOW, 0, 1 = segment lines are active-low; inverted before decode.
- EN_ACTIVE_LOW, 0, 1 = enable lines are active-low; inverted before use.
- SETTLE, 4, consecutive identical cycles required before a digit window is sampled (range 1..15).
- TIMEOUT, 1024, cycles without a frame commit before stale is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- seg_in  in  8  segment lines; bit0=A … bit6=G, bit7=dp
- en_in  in  4  digit enables; bit k selects digit k
- digit_code  out  16  committed frame; nibble k = digit k
- digit_dp  out  4  committed decimal-point bits
- digit_blank  out  4  digit k had all of A..G off
- digit_err  out  4  digit k had an unrecognised pattern
- frame_valid  out  1  one-cycle pulse when a new frame is committed
- stale  out  1  no commit for TIMEOUT cycles

Behaviour:
- Reset: synchronous, active-high, and it overrides everything. While rst=1, every output, shadow register, seen mask, counter and input register is cleared to 0.
- Input stage:
  - seg_in and en_in are polarity-normalised, then registered once: {en_r, seg_r}.
  - All further logic uses the registered values.
- Settle counter:
  - Reloads to 1 when {en_r, seg_r} differs from its value in the previous cycle.
  - Otherwise increments, saturating at SETTLE.
- Capture rule: a capture fires in the single cycle where all of the following hold:
  - the settle counter reaches SETTLE (transition into SETTLE, not while held there);
  - en_r is exactly one-hot.
- Enable values that block capture:
  - en_r==0 is a blanking gap: no capture.
  - More than one bit set is illegal: no capture, and the seg value is ignored.
- Capture of digit k:
  - Decode seg_r[6:0] into shadow nibble k, shadow blank k and shadow err k.
  - Store seg_r[7] into shadow dp k.
  - Set seen[k].
  - A re-capture of digit k within the same frame overwrites its shadow; seen is unchanged.
- Decode table, seg_r[6:0] → nibble:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
  - 0x00 → blank=1, nibble=0, err=0.
  - Any other pattern → err=1, nibble=0, blank=0.
- Commit:
  - When a capture makes seen==4'b1111, the next cycle copies all shadows to the outputs, pulses frame_valid high for exactly 1 cycle, clears seen and clears stale.
  - Outputs hold between commits.
- Latency: a steady digit window driven from input cycle t is captured at the end of cycle t+SETTLE. If that capture completes the frame, outputs update with frame_valid=1 in cycle t+SETTLE+1.
- Stale counter:
  - Increments every cycle; reloads to 0 on a commit.
  - When it reaches TIMEOUT, stale=1; the counter then saturates.
  - A commit in the same cycle the timeout would be reached wins: stale stays 0 and the counter restarts.
- Digit order: independent of scan order. Any permutation of the four digits completes a frame.
- Reset mid-frame: partial seen and shadow contents are discarded; the committed outputs also return to 0.

Test Plan:
- Reset: assert rst 2 cycles with random seg_in/en_in → all outputs 0, frame_valid never pulses. After release, idle input (en_in=0) for 1023 cycles → stale=0; at cycle 1024 → stale=1.
- Clean scan, SETTLE=4: drive en=0001/seg=0x06, en=0010/seg=0x5B, en=0100/seg=0x4F, en=1000/seg=0xE6, each for 6 cycles.
  - Expect one frame_valid pulse 5 cycles after the last window starts.
  - Expect digit_code=0x4321, digit_dp=4'b1000, blank=0, err=0.
- Glitch rejection: 2-cycle en=0011 and 3-cycle windows (shorter than SETTLE) interleaved with a valid scan → no captures from them; the frame still commits with the correct values.
- Special patterns: digit0=0x00, digit1=0x12, digit2=0x71, digit3=0x3F → digit_code=0x0F00, blank=4'b0001, err=4'b0010.
- Rescan / order: scan order 3,1,1(seg changed from 0x06 to 0x7F),0,2 → commit after digit 2, with nibble1=8. A reversed-order second frame commits again with frame_valid pulsed once more.
- Reset mid-frame plus polarity: with SEG_ACTIVE_LOW=1 and EN_ACTIVE_LOW=1, capture 3 digits, then assert rst → no commit. A fresh full scan afterwards commits normally, using inverted decoding (seg_in=~0x3F → nibble 0).
